rle_stream_enc: RTL
===================

# rle_stream_enc

Parametrised run-length encoder, next generation of the team's frame RLE compressor. Reads a plaintext frame of `message_size` bytes from the shared single-port dpsram, starting at word address `message_addr`. Encodes it as (byte, count) pairs with a configurable maximum run length, packs two pairs per 32-bit word and writes them from `rle_addr`. It handles sizes that are not a multiple of 4, and zero size; it also splits long runs, reports `busy`, and ignores `start` while busy.

## Interface
- ADDR_W, 16, dpsram address width; byte addresses are taken modulo 2^ADDR_W.
- MAX_RUN, 255, largest count per pair, legal range 1..255; longer runs are split.
- clk  in  1  clock.
- nreset  in  1  reset: asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- message_addr  in  32  plaintext start byte address; bits [1:0] are ignored.
- message_size  in  32  plaintext length in bytes; 0 is legal.
- rle_addr  in  32  output start byte address; bits [1:0] are ignored.
- rle_size  out  32  output length in bytes (2 × pairs); reset 0.
- done  out  1  high from completion until the next accepted start; reset 0.
- busy  out  1  high from an accepted start until the FIN cycle, inclusive; reset 0.
- port_A_clk  out  1  equals clk.
- port_A_addr  out  ADDR_W  dpsram byte address; reset 0.
- port_A_data_out  in  32  dpsram read data, valid in the cycle after the address is sampled.
- port_A_data_in  out  32  dpsram write data; reset 0.
- port_A_we  out  1  write enable; reset 0.

## Operation
- States: IDLE, READ, LATCH, SCAN, WRITE, FLUSH, FIN.
- IDLE:
  - On start: latch the addresses and size, clear the pair count, the pack buffer and the run, and clear done.
  - Go to FIN if message_size == 0, otherwise go to READ.
- READ: drive rd_addr with we = 0, then go to LATCH.
- LATCH: capture port_A_data_out into the word register, set lane = 0, advance rd_addr by 4, then go to SCAN.
- SCAN processes one byte per cycle, lane 0 first (bits [7:0]). Let b be the current lane byte:
  - If no run is open: open run (b, 1).
  - Else if b == run byte and count < MAX_RUN: increment count.
  - Else: emit (run byte, count) and open run (b, 1).
  - The consumed-byte counter increments on every SCAN cycle.
- Emit rules:
  - Pair format is count in bits [7:0] and byte in bits [15:8] of a half.
  - The first pair goes to half [15:0], the second pair to half [31:16].
  - Emitting the second pair sends SCAN to WRITE next.
  - Each emitted pair adds 2 to rle_size.
- SCAN exit, taking the first match in this order:
  - Second pair emitted: go to WRITE.
  - Consumed == message_size: go to FLUSH.
  - lane == 3: go to READ.
  - Otherwise: increment lane and stay in SCAN.
  - Lanes beyond message_size in the last word are never examined.
- WRITE:
  - Drive wr_addr with data_in = pack buffer and we = 1.
  - Advance wr_addr by 4 and clear the buffer.
  - Then apply the SCAN exit tests (finished, lane == 3, otherwise increment lane), skipping the first one.
- FLUSH:
  - Emit the open run.
  - If the buffer then holds one pair, write it with [31:16] = 0; if it holds two, write both.
  - we = 1 for exactly this one cycle, then go to FIN.
- FIN: we = 0, busy = 0, set done, go to IDLE.
- Arithmetic:
  - Address registers are 32-bit, incrementing by 4 modulo 2^32; port_A_addr carries only their low ADDR_W bits.
  - The consumed counter and rle_size are 32-bit.
  - count is 8-bit and never exceeds MAX_RUN.
- port_A_addr shows wr_addr whenever we = 1, otherwise rd_addr.

## Timing
- Read latency: address in READ at cycle n, data captured in LATCH at n+1, first SCAN at n+2.
- Steady state per input word: READ + LATCH + 4 SCAN cycles, plus 1 cycle per WRITE.
- Zero size: start sampled at edge k gives FIN in cycle k+1; done is high and busy low from edge k+2.
- start while busy: ignored, no effect on any register.
- Reset mid-operation: all state and outputs return to reset values at once; we drops asynchronously; no partial write is completed.
- rle_size is stable whenever done = 1, and holds until the next accepted start.

## Test plan
- Bytes 41 42 43 44 (word 0x44434241), size 4 -> writes 0x42014101 then 0x44014301; rle_size 8; done high.
- 300 bytes of 0xAA, MAX_RUN 255 -> single write 0xAA2DAAFF; rle_size 4.
- Size 5, words 0x11111111 and 0xFFFF FF11 -> single write 0x00001105; upper lanes ignored; rle_size 2.
- Size 0 with start -> no we pulse; done asserted 2 edges after start; rle_size 0.
- start pulsed mid-frame -> output identical to an undisturbed run; nreset low mid-frame -> we = 0, busy = 0, done = 0, rle_size = 0 at once, and a subsequent normal frame encodes correctly.
- ADDR_W 8, rle_addr 0xFC, 4 distinct bytes -> writes at 0xFC then 0x00, showing address wrap.

Source files
------------

// File: rtl/rle_stream_enc_if.sv
// ---------------------------------------------------------------------------
// rle_stream_enc_if
//   Single-port dpsram bus used by the run-length encoder.
//
//   Signals:
//     port_A_clk       memory clock (driven by the master, equals its clk)
//     port_A_addr      byte address, ADDR_W bits
//     port_A_data_out  read data from memory, valid the cycle after the
//                      address is sampled
//     port_A_data_in   write data towards memory
//     port_A_we        write enable
//
//   Modports:
//     master  the encoder side
//     slave   the memory side
//
//   Handshake: there is no valid/ready pair on this bus. A read is the
//   address held for one cycle with we = 0, and the data is taken on the
//   following cycle; a write is one cycle with we = 1, address and data
//   all valid together. The memory never stalls.
// ---------------------------------------------------------------------------
interface rle_stream_enc_if #(
    parameter int ADDR_W = 16
);
    logic              port_A_clk;
    logic [ADDR_W-1:0] port_A_addr;
    logic [31:0]       port_A_data_out;
    logic [31:0]       port_A_data_in;
    logic              port_A_we;

    modport master (
        output port_A_clk,
        output port_A_addr,
        output port_A_data_in,
        output port_A_we,
        input  port_A_data_out
    );

    modport slave (
        input  port_A_clk,
        input  port_A_addr,
        input  port_A_data_in,
        input  port_A_we,
        output port_A_data_out
    );
endinterface

// File: rtl/rle_stream_enc.sv
// ---------------------------------------------------------------------------
// rle_stream_enc
//   Run-length encoder. Reads message_size bytes from dpsram starting at
//   message_addr, encodes them as (byte, count) pairs with count capped at
//   MAX_RUN, packs two pairs per 32-bit word (first pair in [15:0], count in
//   the low byte of each half) and writes the words from rle_addr.
//
//   Ports:
//     clk, nreset       clock, asynchronous active-low reset
//     start             one-cycle request, only looked at in IDLE
//     message_addr      plaintext start byte address ([1:0] ignored)
//     message_size      plaintext length in bytes, 0 allowed
//     rle_addr          output start byte address ([1:0] ignored)
//     rle_size          output length in bytes (2 per pair)
//     done              high from completion until the next accepted start
//     busy              high from an accepted start through the FIN cycle
//     mem               dpsram bus (master side)
//     o_dbg_state       current FSM state
//     o_dbg_rd_addr     read address register
//     o_dbg_wr_addr     write address register
// ---------------------------------------------------------------------------
module rle_stream_enc #(
    parameter int ADDR_W  = 16,
    parameter int MAX_RUN = 255
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    start,
    input  logic [31:0]             message_addr,
    input  logic [31:0]             message_size,
    input  logic [31:0]             rle_addr,
    output logic [31:0]             rle_size,
    output logic                    done,
    output logic                    busy,
    rle_stream_enc_if.master        mem,
    output logic [2:0]              o_dbg_state,
    output logic [31:0]             o_dbg_rd_addr,
    output logic [31:0]             o_dbg_wr_addr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_FLUSH = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    localparam logic [7:0] MAX_CNT = 8'(MAX_RUN);

    logic [2:0]  r_state;
    logic [31:0] r_rd_addr;
    logic [31:0] r_wr_addr;
    logic [31:0] r_size;
    logic [31:0] r_consumed;
    logic [31:0] r_word;
    logic [1:0]  r_lane;
    logic        r_run_open;
    logic [7:0]  r_run_byte;
    logic [7:0]  r_run_cnt;
    logic [31:0] r_buf;
    logic        r_half;      // low half of r_buf already holds a pair
    logic [31:0] r_rle_size;
    logic        r_done;
    logic        r_busy;

    logic [7:0]  w_byte;
    logic        w_extend;
    logic        w_emit;
    logic [15:0] w_pair;
    logic [31:0] w_consumed_nxt;
    logic [31:0] w_flush_data;
    logic        w_we;

    assign w_byte         = r_word[{r_lane, 3'b000} +: 8];
    assign w_extend       = r_run_open && (w_byte == r_run_byte) && (r_run_cnt < MAX_CNT);
    assign w_emit         = r_run_open && !w_extend;
    assign w_pair         = {r_run_byte, r_run_cnt};
    assign w_consumed_nxt = r_consumed + 32'd1;
    // FLUSH sees at most one pair already buffered; the open run joins it.
    assign w_flush_data   = r_half ? {w_pair, r_buf[15:0]} : {16'h0000, w_pair};
    assign w_we           = (r_state == S_WRITE) || (r_state == S_FLUSH);

    assign mem.port_A_clk     = clk;
    assign mem.port_A_we      = w_we;
    assign mem.port_A_addr    = w_we ? r_wr_addr[ADDR_W-1:0] : r_rd_addr[ADDR_W-1:0];
    assign mem.port_A_data_in = (r_state == S_WRITE) ? r_buf :
                                (r_state == S_FLUSH) ? w_flush_data : 32'h0;

    assign rle_size      = r_rle_size;
    assign done          = r_done;
    assign busy          = r_busy;
    assign o_dbg_state   = r_state;
    assign o_dbg_rd_addr = r_rd_addr;
    assign o_dbg_wr_addr = r_wr_addr;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= S_IDLE;
            r_rd_addr  <= 32'h0;
            r_wr_addr  <= 32'h0;
            r_size     <= 32'h0;
            r_consumed <= 32'h0;
            r_word     <= 32'h0;
            r_lane     <= 2'd0;
            r_run_open <= 1'b0;
            r_run_byte <= 8'h0;
            r_run_cnt  <= 8'h0;
            r_buf      <= 32'h0;
            r_half     <= 1'b0;
            r_rle_size <= 32'h0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rd_addr  <= message_addr & 32'hFFFF_FFFC;
                        r_wr_addr  <= rle_addr & 32'hFFFF_FFFC;
                        r_size     <= message_size;
                        r_consumed <= 32'h0;
                        r_rle_size <= 32'h0;
                        r_buf      <= 32'h0;
                        r_half     <= 1'b0;
                        r_run_open <= 1'b0;
                        r_run_cnt  <= 8'h0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= (message_size == 32'h0) ? S_FIN : S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_word    <= mem.port_A_data_out;
                    r_lane    <= 2'd0;
                    r_rd_addr <= r_rd_addr + 32'd4;
                    r_state   <= S_SCAN;
                end
                S_SCAN: begin
                    r_consumed <= w_consumed_nxt;
                    if (w_extend) begin
                        r_run_cnt <= r_run_cnt + 8'd1;
                    end else begin
                        r_run_open <= 1'b1;
                        r_run_byte <= w_byte;
                        r_run_cnt  <= 8'd1;
                    end
                    if (w_emit) begin
                        r_rle_size <= r_rle_size + 32'd2;
                        if (r_half) begin
                            r_buf[31:16] <= w_pair;
                        end else begin
                            r_buf[15:0] <= w_pair;
                            r_half      <= 1'b1;
                        end
                    end
                    // Lane is not advanced on the way to WRITE; WRITE does it.
                    if (w_emit && r_half) begin
                        r_state <= S_WRITE;
                    end else if (w_consumed_nxt == r_size) begin
                        r_state <= S_FLUSH;
                    end else if (r_lane == 2'd3) begin
                        r_state <= S_READ;
                    end else begin
                        r_lane <= r_lane + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_wr_addr <= r_wr_addr + 32'd4;
                    r_buf     <= 32'h0;
                    r_half    <= 1'b0;
                    if (r_consumed == r_size) begin
                        r_state <= S_FLUSH;
                    end else if (r_lane == 2'd3) begin
                        r_state <= S_READ;
                    end else begin
                        r_lane  <= r_lane + 2'd1;
                        r_state <= S_SCAN;
                    end
                end
                S_FLUSH: begin
                    r_rle_size <= r_rle_size + 32'd2;
                    r_wr_addr  <= r_wr_addr + 32'd4;
                    r_buf      <= 32'h0;
                    r_half     <= 1'b0;
                    r_run_open <= 1'b0;
                    r_state    <= S_FIN;
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
